// File: rtl/mic_dma_pkg.sv
// rtl/mic_dma_pkg.sv - shared state type, constants and address helper for the microphone DMA writer
package mic_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SEL,
    WRITE,
    DONE
  } mic_dma_state_t;

  localparam int         NUM_MICS_DEFAULT = 4;
  localparam int         WORD_BYTES       = 4;
  localparam logic [2:0] BURST_ONE        = 3'd1;
  localparam logic [3:0] BE_ALL           = 4'hF;

  // Byte address of a word slot; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] word_idx);
    return base + (word_idx * 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/mic_dma_writer.sv
// rtl/mic_dma_writer.sv - frame-synchronous microphone sample writer onto an Avalon-MM master
// Optional OVERRUN flag for early read_ready pulses is built when MIC_DMA_OVERRUN_EN is defined.
module mic_dma_writer
  import mic_dma_pkg::*;
#(
  parameter int NUM_MICS = NUM_MICS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] AM_ADDR,
  output logic [2:0]  AM_BURSTCOUNT,
  output logic        AM_WRITE,
  output logic [31:0] AM_WRITEDATA,
  output logic [3:0]  AM_BYTEENABLE,
  input  logic        AM_WAITREQUEST,
  input  logic [31:0] mic_data,
  output logic [2:0]  select,
  input  logic        start,
  input  logic        read_ready,
  input  logic [31:0] start_address,
  input  logic [31:0] number_samples,
`ifdef MIC_DMA_OVERRUN_EN
  output logic        OVERRUN,
`endif
  output logic        FINISHED
);

  localparam logic [2:0] LAST_MIC = 3'(NUM_MICS);

  mic_dma_state_t state;
  logic [31:0]    base;
  logic [31:0]    target;
  logic [31:0]    word_cnt;
  logic [31:0]    frame_cnt;
  logic [2:0]     mic_idx;

  assign AM_BURSTCOUNT = BURST_ONE;
  assign AM_BYTEENABLE = BE_ALL;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      base         <= '0;
      target       <= '0;
      word_cnt     <= '0;
      frame_cnt    <= '0;
      mic_idx      <= '0;
      AM_ADDR      <= '0;
      AM_WRITE     <= 1'b0;
      AM_WRITEDATA <= '0;
      select       <= '0;
      FINISHED     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          AM_WRITE <= 1'b0;
          select   <= '0;
          FINISHED <= 1'b0;
          if (start) begin
            base      <= start_address;
            target    <= number_samples;
            word_cnt  <= '0;
            frame_cnt <= '0;
            if (number_samples == 32'd0) begin
              state    <= DONE;
              FINISHED <= 1'b1;
            end else begin
              state <= ARM;
            end
          end
        end

        ARM: begin
          if (!start) begin
            state <= IDLE;
          end else if (read_ready) begin
            mic_idx <= 3'd1;
            select  <= 3'd1;
            state   <= SEL;
          end
        end

        // The external mux has had one cycle to settle on select; capture it now.
        SEL: begin
          if (!start) begin
            state  <= IDLE;
            select <= '0;
          end else begin
            AM_WRITEDATA <= mic_data;
            AM_ADDR      <= word_addr(base, word_cnt);
            AM_WRITE     <= 1'b1;
            state        <= WRITE;
          end
        end

        WRITE: begin
          if (!AM_WAITREQUEST) begin
            AM_WRITE <= 1'b0;
            word_cnt <= word_cnt + 32'd1;
            if (!start) begin
              state  <= IDLE;
              select <= '0;
            end else if (mic_idx < LAST_MIC) begin
              mic_idx <= mic_idx + 3'd1;
              select  <= mic_idx + 3'd1;
              state   <= SEL;
            end else begin
              frame_cnt <= frame_cnt + 32'd1;
              select    <= '0;
              if (frame_cnt + 32'd1 == target) begin
                state    <= DONE;
                FINISHED <= 1'b1;
              end else begin
                state <= ARM;
              end
            end
          end
        end

        DONE: begin
          AM_WRITE <= 1'b0;
          select   <= '0;
          if (!start) begin
            state    <= IDLE;
            FINISHED <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIC_DMA_OVERRUN_EN
  // A frame pulse arriving while the previous frame is still being written is lost; flag it.
  always_ff @(posedge CLK) begin
    if (RESET || (state == IDLE && start)) begin
      OVERRUN <= 1'b0;
    end else if (read_ready && (state == SEL || state == WRITE)) begin
      OVERRUN <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mic_dma_writer.sv
// tb/tb_mic_dma_writer.sv - scoreboard bench for mic_dma_writer (honours MIC_DMA_OVERRUN_EN)
module tb_mic_dma_writer;

  localparam int N = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] samples;
    int          stall_word;
    int          stall_len;
  } vec_t;

  logic        CLK;
  logic        RESET;
  logic [31:0] AM_ADDR;
  logic [2:0]  AM_BURSTCOUNT;
  logic        AM_WRITE;
  logic [31:0] AM_WRITEDATA;
  logic [3:0]  AM_BYTEENABLE;
  logic        AM_WAITREQUEST;
  logic [31:0] mic_data;
  logic [2:0]  select;
  logic        start;
  logic        read_ready;
  logic [31:0] start_address;
  logic [31:0] number_samples;
  logic        FINISHED;
`ifdef MIC_DMA_OVERRUN_EN
  logic        OVERRUN;
`endif

  logic [31:0] mic_base;
  logic [31:0] noise;
  exp_t        sb[$];
  vec_t        vecs[4];
  int          checks;
  int          errors;
  int          acc_cnt;
  int          stall_word;
  int          stall_len;
  int          stall_cnt;
  bit          mon_en;

  assign mic_data = (mic_base + {29'd0, select}) ^ noise;

  mic_dma_writer #(.NUM_MICS(N)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .AM_ADDR        (AM_ADDR),
    .AM_BURSTCOUNT  (AM_BURSTCOUNT),
    .AM_WRITE       (AM_WRITE),
    .AM_WRITEDATA   (AM_WRITEDATA),
    .AM_BYTEENABLE  (AM_BYTEENABLE),
    .AM_WAITREQUEST (AM_WAITREQUEST),
    .mic_data       (mic_data),
    .select         (select),
    .start          (start),
    .read_ready     (read_ready),
    .start_address  (start_address),
    .number_samples (number_samples),
`ifdef MIC_DMA_OVERRUN_EN
    .OVERRUN        (OVERRUN),
`endif
    .FINISHED       (FINISHED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs on every falling edge: chooses waitrequest for the coming edge and scores the bus.
  task automatic monitor_step();
    exp_t e;
    if (!mon_en) return;
    if (RESET || !AM_WRITE) begin
      AM_WAITREQUEST = 1'b0;
      noise = '0;
      return;
    end
    if (sb.size() == 0) begin
      chk("unexpected_write", 32'd1, 32'd0);
      AM_WAITREQUEST = 1'b0;
      return;
    end
    e = sb[0];
    if (acc_cnt == stall_word && stall_cnt < stall_len) begin
      AM_WAITREQUEST = 1'b1;
      noise = 32'hFFFF_FFFF;
      stall_cnt++;
      chk("stall_addr", AM_ADDR, e.addr);
      chk("stall_data", AM_WRITEDATA, e.data);
      chk("stall_sel", {29'd0, select}, {29'd0, e.sel});
    end else begin
      AM_WAITREQUEST = 1'b0;
      noise = '0;
      void'(sb.pop_front());
      chk("wr_addr", AM_ADDR, e.addr);
      chk("wr_data", AM_WRITEDATA, e.data);
      chk("wr_sel", {29'd0, select}, {29'd0, e.sel});
      acc_cnt++;
    end
  endtask

  task automatic wait_q_empty(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d expected=0", tag, sb.size());
    end
  endtask

  task automatic wait_write_high(input string tag);
    int n = 0;
    while (AM_WRITE !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, {31'd0, AM_WRITE}, 32'd1);
  endtask

  task automatic push_frame(input logic [31:0] base, input int frame);
    exp_t e;
    for (int m = 1; m <= N; m++) begin
      e.addr = base + 32'(4 * (frame * N + m - 1));
      e.data = mic_base + 32'(m);
      e.sel  = 3'(m);
      sb.push_back(e);
    end
  endtask

  task automatic arm_monitor(input int sw, input int sl);
    acc_cnt    = 0;
    stall_cnt  = 0;
    stall_word = sw;
    stall_len  = sl;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    arm_monitor(v.stall_word, v.stall_len);
    start_address  = v.base;
    number_samples = v.samples;
    start = 1'b1;
    @(negedge CLK);
    start_address  = 32'hDEAD_BEEF;
    number_samples = 32'd99;
    for (int f = 0; f < int'(v.samples); f++) begin
      mic_base = 32'hC0DE_0000 + 32'(idx << 12) + 32'(f << 4);
      push_frame(v.base, f);
      read_ready = 1'b1;
      @(negedge CLK);
      read_ready = 1'b0;
      wait_q_empty($sformatf("vec%0d_f%0d", idx, f));
      @(negedge CLK);
    end
    @(negedge CLK);
    chk($sformatf("vec%0d_finished", idx), {31'd0, FINISHED}, 32'd1);
    chk($sformatf("vec%0d_write_idle", idx), {31'd0, AM_WRITE}, 32'd0);
    chk($sformatf("vec%0d_select_idle", idx), {29'd0, select}, 32'd0);
    chk($sformatf("vec%0d_word_count", idx), 32'(acc_cnt), v.samples * 32'(N));
    start = 1'b0;
    @(negedge CLK);
    chk($sformatf("vec%0d_finished_clear", idx), {31'd0, FINISHED}, 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    mon_en = 1'b1;
    RESET = 1'b1;
    AM_WAITREQUEST = 1'b0;
    start = 1'b0;
    read_ready = 1'b0;
    start_address = '0;
    number_samples = '0;
    mic_base = '0;
    noise = '0;
    arm_monitor(-1, 0);

    vecs[0] = '{base: 32'h0000_1000, samples: 32'd2, stall_word: -1, stall_len: 0};
    vecs[1] = '{base: 32'h0000_2000, samples: 32'd2, stall_word: 1,  stall_len: 5};
    vecs[2] = '{base: 32'hFFFF_FFF8, samples: 32'd1, stall_word: -1, stall_len: 0};
    vecs[3] = '{base: 32'h0000_3000, samples: 32'd3, stall_word: 6,  stall_len: 2};

    fork
      forever begin
        @(negedge CLK);
        monitor_step();
      end
    join_none

    repeat (3) @(negedge CLK);
    chk("rst_addr", AM_ADDR, 32'd0);
    chk("rst_write", {31'd0, AM_WRITE}, 32'd0);
    chk("rst_data", AM_WRITEDATA, 32'd0);
    chk("rst_select", {29'd0, select}, 32'd0);
    chk("rst_finished", {31'd0, FINISHED}, 32'd0);
    chk("burstcount", {29'd0, AM_BURSTCOUNT}, 32'd1);
    chk("byteenable", {28'd0, AM_BYTEENABLE}, 32'hF);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Zero frames: straight to DONE without touching the bus.
    start_address = 32'h0000_4000;
    number_samples = 32'd0;
    start = 1'b1;
    @(negedge CLK);
    chk("zero_finished", {31'd0, FINISHED}, 32'd1);
    chk("zero_write", {31'd0, AM_WRITE}, 32'd0);
    read_ready = 1'b1;
    @(negedge CLK);
    read_ready = 1'b0;
    chk("zero_finished_hold", {31'd0, FINISHED}, 32'd1);
    chk("zero_select", {29'd0, select}, 32'd0);
    start = 1'b0;
    @(negedge CLK);
    chk("zero_finished_clear", {31'd0, FINISHED}, 32'd0);

    // read_ready while idle is ignored.
    read_ready = 1'b1;
    @(negedge CLK);
    read_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_rr_select", {29'd0, select}, 32'd0);
    chk("idle_rr_write", {31'd0, AM_WRITE}, 32'd0);

    // start dropped while the first word is stalled: that word still lands, then IDLE.
    arm_monitor(0, 4);
    start_address = 32'h0000_5000;
    number_samples = 32'd1;
    start = 1'b1;
    @(negedge CLK);
    mic_base = 32'h5A5A_0000;
    e.addr = 32'h0000_5000;
    e.data = 32'h5A5A_0001;
    e.sel = 3'd1;
    sb.push_back(e);
    read_ready = 1'b1;
    @(negedge CLK);
    read_ready = 1'b0;
    wait_write_high("drop_write_seen");
    start = 1'b0;
    read_ready = 1'b1;
    @(negedge CLK);
    read_ready = 1'b0;
    wait_q_empty("drop");
    repeat (3) @(negedge CLK);
    chk("drop_words", 32'(acc_cnt), 32'd1);
    chk("drop_write", {31'd0, AM_WRITE}, 32'd0);
    chk("drop_finished", {31'd0, FINISHED}, 32'd0);
    chk("drop_select", {29'd0, select}, 32'd0);
`ifdef MIC_DMA_OVERRUN_EN
    chk("overrun_set", {31'd0, OVERRUN}, 32'd1);
    number_samples = 32'd0;
    start = 1'b1;
    @(negedge CLK);
    chk("overrun_clear", {31'd0, OVERRUN}, 32'd0);
    start = 1'b0;
    @(negedge CLK);
`endif

    // RESET in the middle of a stalled write.
    arm_monitor(0, 20);
    start_address = 32'h0000_6000;
    number_samples = 32'd1;
    start = 1'b1;
    @(negedge CLK);
    mic_base = 32'h6600_0000;
    e.addr = 32'h0000_6000;
    e.data = 32'h6600_0001;
    e.sel = 3'd1;
    sb.push_back(e);
    read_ready = 1'b1;
    @(negedge CLK);
    read_ready = 1'b0;
    wait_write_high("rstw_write_seen");
    @(negedge CLK);
    mon_en = 1'b0;
    AM_WAITREQUEST = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("rstw_write", {31'd0, AM_WRITE}, 32'd0);
    chk("rstw_addr", AM_ADDR, 32'd0);
    chk("rstw_data", AM_WRITEDATA, 32'd0);
    chk("rstw_select", {29'd0, select}, 32'd0);
    chk("rstw_finished", {31'd0, FINISHED}, 32'd0);
    sb.delete();
    start = 1'b0;
    AM_WAITREQUEST = 1'b0;
    noise = '0;
    RESET = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_write", {31'd0, AM_WRITE}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
